// File: rtl/dcache_burst_controller.sv
// Write-back / write-allocate D-cache miss controller with multi-beat refill and writeback.
// Optional perf counters: define DCACHE_BURST_CTRL_PERF_EN.
module dcache_burst_controller #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int BEAT_WORDS  = 1,
  localparam int BLOCK_W = WORD_W * BLOCK_WORDS,
  localparam int BEAT_W  = WORD_W * BEAT_WORDS,
  localparam int BEATS   = BLOCK_WORDS / BEAT_WORDS,
  localparam int WBYTES  = WORD_W / 8,
  localparam int OFF_W   = $clog2(BLOCK_W / 8),
  localparam int BA_W    = ADDR_W - OFF_W,
  localparam int BIDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
)(
  input  logic                 i_clock,
  input  logic                 i_reset_n,
`ifdef DCACHE_BURST_CTRL_PERF_EN
  output logic [31:0]          o_perfHits,
  output logic [31:0]          o_perfMisses,
  output logic [31:0]          o_perfWritebacks,
`endif
  input  logic                 i_ren,
  input  logic                 i_wen,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [WBYTES-1:0]    i_byteSelectVector,
  input  logic [WORD_W-1:0]    i_din,
  output logic                 o_stall,
  output logic [WORD_W-1:0]    o_dout,
  input  logic                 i_cacheHit,
  input  logic                 i_cacheDirtyBit,
  input  logic [BA_W-1:0]      i_cacheVictimAddr,
  input  logic [BLOCK_W-1:0]   i_cacheDout,
  output logic [BA_W-1:0]      o_BlockAddr,
  output logic                 o_cacheRen,
  output logic                 o_cacheWen,
  output logic                 o_cacheMemWen,
  output logic                 o_cacheFillDirty,
  output logic [BLOCK_W/8-1:0] o_cacheBytesAccess,
  output logic [BLOCK_W-1:0]   o_cacheDin,
  output logic                 o_memRen,
  output logic                 o_memWen,
  output logic [BA_W-1:0]      o_memAddr,
  output logic [BIDX_W-1:0]    o_memBeat,
  input  logic                 i_memReadReady,
  input  logic                 i_memWriteDone,
  input  logic [BEAT_W-1:0]    i_memDout,
  output logic [BEAT_W-1:0]    o_memDin
);
  localparam int WOFF_W = $clog2(WBYTES);
  localparam int WIDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FETCH, S_FILL} state_t;

  state_t               r_state, w_next;
  logic [BIDX_W-1:0]    r_beat;
  logic [BLOCK_W-1:0]   r_fill;
  logic [BA_W-1:0]      r_blk, r_victim;
  logic [WIDX_W-1:0]    r_widx;
  logic                 r_wen;
  logic [WORD_W-1:0]    r_din;
  logic [WBYTES-1:0]    r_be;
  logic                 r_store_done;

  logic                 w_req, w_last, w_miss;
  logic [WIDX_W-1:0]    w_widx;
  logic [BLOCK_W-1:0]   w_merged;
  logic                 w_unused_lsb;

  assign w_req  = i_ren ^ i_wen;
  assign w_last = (r_beat == BIDX_W'(BEATS - 1));
  assign w_miss = (r_state == S_IDLE) && w_req && !i_cacheHit;

  generate
    if (BLOCK_WORDS > 1) begin : g_widx
      assign w_widx = i_addr[OFF_W-1:WOFF_W];
    end else begin : g_widx1
      assign w_widx = '0;
    end
    if (WOFF_W > 0) begin : g_lsb
      assign w_unused_lsb = ^i_addr[(WOFF_W > 0 ? WOFF_W : 1)-1:0];
    end else begin : g_lsb0
      assign w_unused_lsb = 1'b0;
    end
  endgenerate

  // Pending store bytes overlaid on the refilled block.
  always_comb begin
    w_merged = r_fill;
    for (int b = 0; b < WBYTES; b++)
      if (r_be[b]) w_merged[int'(r_widx)*WORD_W + b*8 +: 8] = r_din[b*8 +: 8];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    o_stall            = 1'b0;
    o_dout             = '0;
    o_cacheRen         = 1'b0;
    o_cacheWen         = 1'b0;
    o_cacheMemWen      = 1'b0;
    o_cacheFillDirty   = 1'b0;
    o_cacheBytesAccess = '0;
    o_cacheDin         = '0;
    o_memRen           = 1'b0;
    o_memWen           = 1'b0;
    o_BlockAddr        = r_blk;
    o_memAddr          = r_blk;
    o_memBeat          = r_beat;
    o_memDin           = i_cacheDout[int'(r_beat)*BEAT_W +: BEAT_W];
    case (r_state)
      S_IDLE: begin
        o_BlockAddr = i_addr[ADDR_W-1:OFF_W];
        if (w_req && i_cacheHit) begin
          if (i_ren) begin
            o_cacheRen = 1'b1;
            o_dout     = i_cacheDout[int'(w_widx)*WORD_W +: WORD_W];
          end else if (!r_store_done) begin
            // store already merged during FILL must not be written twice
            o_cacheWen = 1'b1;
            o_cacheBytesAccess[int'(w_widx)*WBYTES +: WBYTES] = i_byteSelectVector;
            o_cacheDin[int'(w_widx)*WORD_W +: WORD_W]         = i_din;
          end
        end else if (w_req) begin
          o_stall = 1'b1;
          w_next  = i_cacheDirtyBit ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        o_stall   = 1'b1;
        o_memWen  = 1'b1;
        o_memAddr = r_victim;
        if (i_memWriteDone && w_last) w_next = S_FETCH;
      end
      S_FETCH: begin
        o_stall  = 1'b1;
        o_memRen = 1'b1;
        if (i_memReadReady && w_last) w_next = S_FILL;
      end
      S_FILL: begin
        o_stall            = 1'b1;
        o_cacheMemWen      = 1'b1;
        o_cacheBytesAccess = '1;
        o_cacheDin         = r_wen ? w_merged : r_fill;
        o_cacheFillDirty   = r_wen;
        w_next             = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_beat       <= '0;
      r_fill       <= '0;
      r_blk        <= '0;
      r_victim     <= '0;
      r_widx       <= '0;
      r_wen        <= 1'b0;
      r_din        <= '0;
      r_be         <= '0;
      r_store_done <= 1'b0;
    end else begin
      r_store_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_miss) begin
          r_blk    <= i_addr[ADDR_W-1:OFF_W];
          r_victim <= i_cacheVictimAddr;
          r_widx   <= w_widx;
          r_wen    <= i_wen;
          r_din    <= i_din;
          r_be     <= i_byteSelectVector;
          r_beat   <= '0;
        end
        S_WB: if (i_memWriteDone) r_beat <= w_last ? '0 : r_beat + 1'b1;
        S_FETCH: if (i_memReadReady) begin
          r_fill[int'(r_beat)*BEAT_W +: BEAT_W] <= i_memDout;
          r_beat <= w_last ? '0 : r_beat + 1'b1;
        end
        S_FILL: r_store_done <= r_wen;
        default: ;
      endcase
    end
  end

`ifdef DCACHE_BURST_CTRL_PERF_EN
  logic [31:0] r_perfHits, r_perfMisses, r_perfWritebacks;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_perfHits       <= '0;
      r_perfMisses     <= '0;
      r_perfWritebacks <= '0;
    end else begin
      if ((o_cacheRen || o_cacheWen) && r_perfHits != '1) r_perfHits <= r_perfHits + 1'b1;
      if (w_miss && r_perfMisses != '1) r_perfMisses <= r_perfMisses + 1'b1;
      if (w_miss && i_cacheDirtyBit && r_perfWritebacks != '1)
        r_perfWritebacks <= r_perfWritebacks + 1'b1;
    end
  end

  assign o_perfHits       = r_perfHits;
  assign o_perfMisses     = r_perfMisses;
  assign o_perfWritebacks = r_perfWritebacks;
`endif

endmodule

// File: tb/tb_dcache_burst_controller.sv
// Random + directed bench for dcache_burst_controller against a transaction-level miss model.
module tb_dcache_burst_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ren, wen, hit, dirty, rr, wd;
  logic [31:0] addr, din, mdout;
  logic [3:0]  be;
  logic [27:0] victim;
  logic [127:0] cdout;
  logic        stall, cren, cwen, cmwen, cfd, mren, mwen;
  logic [31:0] dout, mdin;
  logic [27:0] blk, maddr;
  logic [15:0] cba;
  logic [127:0] cdin;
  logic [1:0]  mbeat;

  logic        hit2, dirty2, rr2, wd2;
  logic [27:0] victim2;
  logic [127:0] cdout2;
  logic [63:0] mdout2;
  logic        stall2, cren2, cwen2, cmwen2, cfd2, mren2, mwen2;
  logic [31:0] dout2;
  logic [27:0] blk2, maddr2;
  logic [15:0] cba2;
  logic [127:0] cdin2;
  logic [0:0]  mbeat2;
  logic [63:0] mdin2;
`ifdef DCACHE_BURST_CTRL_PERF_EN
  logic [31:0] ph, pm, pw, ph2, pm2, pw2;
`endif

  dcache_burst_controller u_dut (
    .i_clock(clk), .i_reset_n(rst_n),
`ifdef DCACHE_BURST_CTRL_PERF_EN
    .o_perfHits(ph), .o_perfMisses(pm), .o_perfWritebacks(pw),
`endif
    .i_ren(ren), .i_wen(wen), .i_addr(addr), .i_byteSelectVector(be), .i_din(din),
    .o_stall(stall), .o_dout(dout), .i_cacheHit(hit), .i_cacheDirtyBit(dirty),
    .i_cacheVictimAddr(victim), .i_cacheDout(cdout), .o_BlockAddr(blk),
    .o_cacheRen(cren), .o_cacheWen(cwen), .o_cacheMemWen(cmwen), .o_cacheFillDirty(cfd),
    .o_cacheBytesAccess(cba), .o_cacheDin(cdin), .o_memRen(mren), .o_memWen(mwen),
    .o_memAddr(maddr), .o_memBeat(mbeat), .i_memReadReady(rr), .i_memWriteDone(wd),
    .i_memDout(mdout), .o_memDin(mdin));

  dcache_burst_controller #(.BEAT_WORDS(2)) u_dut2 (
    .i_clock(clk), .i_reset_n(rst_n),
`ifdef DCACHE_BURST_CTRL_PERF_EN
    .o_perfHits(ph2), .o_perfMisses(pm2), .o_perfWritebacks(pw2),
`endif
    .i_ren(ren), .i_wen(wen), .i_addr(addr), .i_byteSelectVector(be), .i_din(din),
    .o_stall(stall2), .o_dout(dout2), .i_cacheHit(hit2), .i_cacheDirtyBit(dirty2),
    .i_cacheVictimAddr(victim2), .i_cacheDout(cdout2), .o_BlockAddr(blk2),
    .o_cacheRen(cren2), .o_cacheWen(cwen2), .o_cacheMemWen(cmwen2), .o_cacheFillDirty(cfd2),
    .o_cacheBytesAccess(cba2), .o_cacheDin(cdin2), .o_memRen(mren2), .o_memWen(mwen2),
    .o_memAddr(maddr2), .o_memBeat(mbeat2), .i_memReadReady(rr2), .i_memWriteDone(wd2),
    .i_memDout(mdout2), .o_memDin(mdin2));

  int n_vec = 0, n_err = 0;

  // Miss modelled as a transaction: beats left to write back, beats left to read, then one fill.
  bit          m_busy, m_sdone, m_st;
  int          m_wb_left, m_rd_left, m_widx;
  logic [27:0] m_blk, m_victim;
  logic [31:0] m_din;
  logic [3:0]  m_be;
  logic [127:0] m_buf;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sdone = 0; m_st = 0; m_wb_left = 0; m_rd_left = 0; m_widx = 0;
    m_blk = '0; m_victim = '0; m_din = '0; m_be = '0; m_buf = '0;
  endtask

  function automatic logic [127:0] merged();
    logic [127:0] r;
    r = m_buf;
    for (int b = 0; b < 4; b++)
      if (m_be[b]) r[m_widx*32 + b*8 +: 8] = m_din[b*8 +: 8];
    return r;
  endfunction

  task automatic model_step();
    if (!m_busy) begin
      m_sdone = 0;
      if ((ren ^ wen) && !hit) begin
        m_busy = 1; m_blk = addr[31:4]; m_victim = victim; m_widx = int'(addr[3:2]);
        m_st = wen; m_din = din; m_be = be;
        m_wb_left = dirty ? 4 : 0; m_rd_left = 4;
      end
    end else if (m_wb_left > 0) begin
      if (wd) m_wb_left--;
    end else if (m_rd_left > 0) begin
      if (rr) begin m_buf[(4 - m_rd_left)*32 +: 32] = mdout; m_rd_left--; end
    end else begin
      m_busy = 0; m_sdone = m_st;
    end
  endtask

  task automatic compare();
    logic req;
    int widx, eb;
    logic e_stall, e_cren, e_cwen, e_cmwen, e_cfd, e_mren, e_mwen;
    logic [31:0] e_dout;
    logic [15:0] e_cba;
    logic [127:0] e_cdin;
    logic [27:0] e_blk, e_maddr;
    e_stall = 0; e_cren = 0; e_cwen = 0; e_cmwen = 0; e_cfd = 0; e_mren = 0; e_mwen = 0;
    e_dout = '0; e_cba = '0; e_cdin = '0; e_blk = '0; e_maddr = '0; eb = 0;
    req = ren ^ wen;
    widx = int'(addr[3:2]);
    if (!m_busy) begin
      e_blk = addr[31:4];
      if (req && hit) begin
        if (ren) begin
          e_cren = 1; e_dout = cdout[widx*32 +: 32];
        end else if (!m_sdone) begin
          e_cwen = 1; e_cba = 16'(be) << (widx*4); e_cdin = 128'(din) << (widx*32);
        end
      end else if (req) e_stall = 1;
    end else begin
      e_stall = 1; e_blk = m_blk;
      if (m_wb_left > 0) begin e_mwen = 1; e_maddr = m_victim; eb = 4 - m_wb_left; end
      else if (m_rd_left > 0) begin e_mren = 1; e_maddr = m_blk; eb = 4 - m_rd_left; end
      else begin e_cmwen = 1; e_cba = '1; e_cfd = m_st; e_cdin = m_st ? merged() : m_buf; end
    end
    chk("stall", stall, e_stall);
    chk("dout", dout, e_dout);
    chk("cacheRen", cren, e_cren);
    chk("cacheWen", cwen, e_cwen);
    chk("cacheMemWen", cmwen, e_cmwen);
    chk("cacheFillDirty", cfd, e_cfd);
    chk("cacheBytesAccess", cba, e_cba);
    chk("cacheDin", cdin, e_cdin);
    chk("BlockAddr", blk, e_blk);
    chk("memRen", mren, e_mren);
    chk("memWen", mwen, e_mwen);
    if (e_mren || e_mwen) begin
      chk("memAddr", maddr, e_maddr);
      chk("memBeat", mbeat, 128'(eb));
    end
    if (e_mwen) chk("memDin", mdin, cdout[eb*32 +: 32]);
  endtask

  task automatic eval(); #4; compare(); endtask
  task automatic adv(); @(posedge clk); model_step(); #1; endtask

  task automatic idle_in();
    ren = 0; wen = 0; addr = '0; din = '0; be = '0; hit = 0; dirty = 0; victim = '0;
    cdout = '0; rr = 0; wd = 0; mdout = '0;
  endtask

  int nb;
  bit done;
  logic [0:0] seq [2];

  initial begin
    idle_in();
    hit2 = 1; dirty2 = 0; rr2 = 0; wd2 = 0; victim2 = '0; cdout2 = '0; mdout2 = '0;
    rst_n = 0; model_reset();
    #2; compare();
    chk("reset_stall", stall, 0);
    @(posedge clk); #1; rst_n = 1;

    // Read hit, word 1 of the block at 0x100
    ren = 1; addr = 32'h104; hit = 1; cdout = 128'h0000_0000_0000_0000_DEADBEEF_0000_0000;
    eval();
    chk("rdhit_dout", dout, 32'hDEADBEEF); chk("rdhit_ren", cren, 1);
    chk("rdhit_stall", stall, 0); chk("rdhit_mem", {mren, mwen}, 0);
    adv();

    // Read miss, clean victim
    ren = 1; addr = 32'h108; hit = 0; dirty = 0; cdout = '0;
    eval(); chk("rdmiss_stall", stall, 1); adv();
    ren = 0; addr = '0;
    for (int k = 0; k < 4; k++) begin
      rr = 1; mdout = 32'(k + 1) * 32'h11;
      eval(); chk("rdmiss_beat", mbeat, 128'(k)); adv();
    end
    rr = 0;
    eval();
    chk("rdmiss_fill", cdin, 128'h00000044_00000033_00000022_00000011);
    chk("rdmiss_mwen", cmwen, 1);
    adv();
    ren = 1; addr = 32'h108; hit = 1; cdout = 128'h00000044_00000033_00000022_00000011;
    eval(); chk("replay_dout", dout, 32'h33); chk("replay_stall", stall, 0); adv();

    // Store miss, dirty victim
    idle_in();
    wen = 1; addr = 32'h208; din = 32'hCAFE0000; be = 4'b1100; dirty = 1; victim = 28'hA0;
    eval(); adv();
    idle_in(); cdout = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    eval(); chk("wb_hold_addr", maddr, 28'hA0); adv();
    for (int k = 0; k < 4; k++) begin
      wd = 1;
      eval(); chk("wb_addr", maddr, 28'hA0); chk("wb_wen", mwen, 1); adv();
    end
    wd = 0;
    for (int k = 0; k < 4; k++) begin
      rr = 1; mdout = 32'(k + 1) * 32'h11;
      eval(); chk("st_fetch_ren", mren, 1); adv();
    end
    rr = 0;
    eval();
    chk("st_fill", cdin, 128'h00000044_CAFE0033_00000022_00000011);
    chk("st_fill_dirty", cfd, 1);
    adv();
    wen = 1; addr = 32'h208; din = 32'hCAFE0000; be = 4'b1100; hit = 1;
    eval(); chk("st_no_rewrite", cwen, 0); chk("st_done_stall", stall, 0); adv();

    // ren and wen together is no request
    idle_in(); ren = 1; wen = 1;
    eval(); chk("both_stall", stall, 0); chk("both_strobes", {cren, cwen}, 0); adv();
    idle_in();
    eval(); chk("both_idle", {stall, mren, mwen}, 0); adv();

    // Reset in the middle of a refill
    ren = 1; addr = 32'h300; eval(); adv();
    idle_in();
    for (int k = 0; k < 2; k++) begin rr = 1; mdout = $urandom; eval(); adv(); end
    rr = 0; eval(); chk("pre_rst_beat", mbeat, 2); chk("pre_rst_ren", mren, 1);
    rst_n = 0; model_reset(); #1;
    chk("rst_stall", stall, 0); chk("rst_ren", mren, 0); chk("rst_beat", mbeat, 0);
    compare();
    @(posedge clk); #1; rst_n = 1;
    eval(); chk("post_rst_stall", stall, 0); adv();

    // Two-word beats: two handshakes per phase
    idle_in(); ren = 1; addr = 32'h400; hit = 1; hit2 = 0;
    eval(); adv();
    ren = 0; hit2 = 1; rr2 = 1; nb = 0; done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      eval();
      if (mren2) begin
        if (nb < 2) seq[nb] = mbeat2;
        nb++;
        mdout2 = (mbeat2 == 1'b0) ? 64'h00000022_00000011 : 64'h00000044_00000033;
      end
      if (cmwen2) begin
        chk("beat2_fill", cdin2, 128'h00000044_00000033_00000022_00000011);
        done = 1;
      end
      adv();
    end
    rr2 = 0;
    chk("beat2_done", done, 1);
    chk("beat2_count", nb, 2);
    chk("beat2_seq0", seq[0], 0);
    chk("beat2_seq1", seq[1], 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ren = $urandom; wen = $urandom; addr = $urandom;
      din = $urandom; be = 4'($urandom);
      hit = ($urandom_range(0, 3) != 0); dirty = $urandom; victim = 28'($urandom);
      cdout = {$urandom, $urandom, $urandom, $urandom};
      rr = ($urandom_range(0, 2) != 0); wd = ($urandom_range(0, 2) != 0); mdout = $urandom;
      eval(); adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
